// File: rtl/relu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : relu_seq_ctrl
//  Brief    : Streams a captured pre-activation vector through one shared
//             ReLU stage, one element per valid/ready handshake, and counts
//             the negative elements that were clipped to zero. A bypass mode
//             passes values through unchanged for a linear output layer.
//  Revision : 1.0  initial release
// ============================================================================
module relu_seq_ctrl #(
  parameter int NBITS      = 16,
  parameter int NUM_NEURON = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        bypass,
  input  logic [NUM_NEURON*NBITS-1:0] vec_in,
  output logic [NBITS-1:0]            out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            clip_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              NSLOT    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);

  state_t                      state_q, state_d;
  logic [NUM_NEURON*NBITS-1:0] vec_q, vec_d;
  logic                        bypass_q, bypass_d;
  logic [NBITS-1:0]            data_q, data_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        valid_q, valid_d;
  logic [CNT_W-1:0]            clip_q, clip_d;

  // Captured vector viewed as an index-addressable array; slots beyond
  // NUM_NEURON (when IDX_W over-covers) read as zero and are never selected.
  logic [NBITS-1:0] elem [NSLOT];

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_elem
    if (gi < NUM_NEURON) begin : g_live
      assign elem[gi] = vec_q[gi*NBITS +: NBITS];
    end else begin : g_pad
      assign elem[gi] = '0;
    end
  end

  // Activation: negatives clip to zero unless the layer is linear.
  function automatic logic [NBITS-1:0] act(input logic [NBITS-1:0] x,
                                           input logic             byp);
    act = (!byp && x[NBITS-1]) ? '0 : x;
  endfunction

  logic             hs;
  logic [IDX_W-1:0] idx_nxt;

  assign hs      = valid_q & out_ready;
  assign idx_nxt = idx_q + IDX_W'(1);

  // State register and registered outputs; reset aborts any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      bypass_q <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      clip_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      bypass_q <= bypass_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      clip_q   <= clip_d;
    end
  end

  // Next-state logic: capture on start, advance one element per handshake.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    bypass_d = bypass_q;
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    clip_d   = clip_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d    = vec_in;
          bypass_d = bypass;
          idx_d    = '0;
          data_d   = act(vec_in[NBITS-1:0], bypass);
          valid_d  = 1'b1;
          clip_d   = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          // Count on the raw value actually handed over, once per element.
          if (!bypass_q && elem[idx_q][NBITS-1]) begin
            clip_d = clip_q + CNT_W'(1);
          end
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d  = idx_nxt;
            data_d = act(elem[idx_nxt], bypass_q);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign clip_cnt  = clip_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_relu_seq_ctrl
//  Brief    : Self-checking bench for relu_seq_ctrl: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_seq_ctrl;

  localparam int NBITS = 16;
  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               bypass;
  logic [N*NBITS-1:0] vec_in;
  logic [NBITS-1:0]   out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   clip_cnt;

  int checks   = 0;
  int failures = 0;

  relu_seq_ctrl #(
    .NBITS(NBITS), .NUM_NEURON(N), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bypass(bypass), .vec_in(vec_in),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // A vector is either in flight (m_active, m_pos = element on offer),
  // in its single done cycle (m_done), or absent.
  bit              m_active;
  bit              m_done;
  int              m_pos;
  int              m_clip;
  bit              m_byp;
  logic [NBITS-1:0] m_raw [N];

  function automatic logic [NBITS-1:0] relu(input logic [NBITS-1:0] x, input bit byp);
    if (byp) return x;
    return ($signed(x) < 0) ? '0 : x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_pos = 0; m_clip = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        for (int i = 0; i < N; i++) m_raw[i] = vec_in[i*NBITS +: NBITS];
        m_byp = bypass; m_pos = 0; m_clip = 0; m_active = 1;
      end
    end else if (out_ready) begin
      if (!m_byp && $signed(m_raw[m_pos]) < 0) m_clip++;
      if (m_pos == N-1) begin m_active = 0; m_done = 1; end
      else m_pos++;
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [NBITS-1:0] cap_q[$];
  int               done_seen = 0;

  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, m_active});
    check("busy",      {31'd0, busy},      {31'd0, (m_active || m_done)});
    check("done",      {31'd0, done},      {31'd0, m_done});
    check("clip_cnt",  {29'd0, clip_cnt},  m_clip);
    if (m_active) begin
      check("out_data", {16'd0, out_data}, {16'd0, relu(m_raw[m_pos], m_byp)});
      check("out_idx",  {30'd0, out_idx},  m_pos);
    end
    if (!rst && out_valid && out_ready) cap_q.push_back(out_data);
    if (!rst && done) done_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_cap(input string name, input int base,
                           input logic [NBITS-1:0] e0, input logic [NBITS-1:0] e1,
                           input logic [NBITS-1:0] e2, input logic [NBITS-1:0] e3);
    logic [NBITS-1:0] exp [4];
    exp = '{e0, e1, e2, e3};
    check({name, "_count"}, cap_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < cap_q.size())
        check(name, {16'd0, cap_q[base+i]}, {16'd0, exp[i]});
  endtask

  int base;
  int dbase;

  initial begin
    rst = 1'b1; start = 1'b0; bypass = 1'b0; vec_in = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_idx",  {30'd0, out_idx},  32'd0);
    rst = 1'b0;
    tick();

    // Mixed signs, ready high: consecutive outputs, two clipped.
    base = cap_q.size(); dbase = done_seen;
    vec_in = {16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
    bypass = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check_cap("relu_vec", base, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000);
    check("relu_clip", {29'd0, clip_cnt}, 32'd2);
    check("relu_done", done_seen - dbase, 32'd1);

    // Bypass: values unchanged, nothing clipped.
    base = cap_q.size();
    bypass = 1'b1; start = 1'b1; tick(); start = 1'b0; bypass = 1'b0;
    repeat (6) tick();
    check_cap("byp_vec", base, 16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF);
    check("byp_clip", {29'd0, clip_cnt}, 32'd0);

    // Backpressure: stall three cycles while element 1 is on offer.
    base = cap_q.size();
    vec_in = {16'h7000, 16'h0001, 16'h9000, 16'h8000};
    start = 1'b1; tick(); start = 1'b0;
    tick();
    out_ready = 1'b0; repeat (3) tick();
    check("bp_idx_held", {30'd0, out_idx}, 32'd1);
    out_ready = 1'b1; repeat (6) tick();
    check_cap("bp_vec", base, 16'h0000, 16'h0000, 16'h0001, 16'h7000);
    check("bp_clip", {29'd0, clip_cnt}, 32'd2);

    // start during RUN with a new vector is ignored.
    base = cap_q.size(); dbase = done_seen;
    vec_in = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    start = 1'b1; tick(); start = 1'b0;
    tick();
    vec_in = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check_cap("ign_vec", base, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    check("ign_done", done_seen - dbase, 32'd1);

    // Asynchronous reset with element 2 on offer.
    vec_in = {16'h0004, 16'h0003, 16'h8002, 16'h8001};
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_rst_idx",  {30'd0, out_idx},  32'd2);
    check("pre_rst_clip", {29'd0, clip_cnt}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy",  {31'd0, busy},      32'd0);
    check("arst_clip",  {29'd0, clip_cnt},  32'd0);
    tick(); rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("restart_idx",   {30'd0, out_idx},   32'd0);
    check("restart_valid", {31'd0, out_valid}, 32'd1);
    repeat (6) tick();

    // Back-to-back: start held high; model checks the 2-cycle gap.
    vec_in = {16'h8000, 16'h8000, 16'h8000, 16'h0001};
    start = 1'b1;
    repeat (7) tick();
    check("b2b_restart_idx",  {30'd0, out_idx},  32'd0);
    check("b2b_restart_clip", {29'd0, clip_cnt}, 32'd0);
    repeat (14) tick();
    start = 1'b0;
    repeat (6) tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      bypass    = ($urandom_range(0, 3) == 0);
      vec_in    = {$urandom, $urandom};
      tick();
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
